axi_rd_arbiter: RTL and testbench

- Shares the single memory read port between two read requesters: m0 = IFU instruction fetch, m1 = LSU load.
- Uses AXI-lite-style AR/R handshakes with the codebase's 3-bit resp encoding (3'b000 = OK).
- Allows one outstanding read at a time, and routes the response back to the granted requester.
- Sits between the IFU/LSU and the memory/SRAM read slave.

---
 rtl/axi_rd_arbiter_pkg.sv | 19 +
 rtl/axi_rd_arb_pick.sv | 36 +++
 rtl/axi_rd_arbiter.sv | 143 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// rtl/axi_rd_arbiter_pkg.sv - shared state, grant and response encodings for the read arbiter
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_AR   = 2'd1,
        ARB_R    = 2'd2
    } arb_state_e;

    // One-hot grant; GNT_NONE means no transaction is owned.
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_M0   = 2'b01,
        GNT_M1   = 2'b10
    } arb_gnt_e;

    localparam logic [2:0] RESP_OKAY = 3'b000;

endpackage

// File: rtl/axi_rd_arb_pick.sv
// rtl/axi_rd_arb_pick.sv - combinational grant select; round-robin when ARB_ROUND_ROBIN_EN is defined
module axi_rd_arb_pick
    import axi_rd_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  arb_gnt_e   last_gnt,
    output arb_gnt_e   gnt
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        gnt = GNT_NONE;
        if (req[0] && req[1]) begin
            // On a tie, whoever was not granted last goes first.
            gnt = (last_gnt == GNT_M0) ? GNT_M1 : GNT_M0;
        end else if (req[1]) begin
            gnt = GNT_M1;
        end else if (req[0]) begin
            gnt = GNT_M0;
        end
    end
`else
    always_comb begin
        gnt = GNT_NONE;
        if (req[1]) begin
            gnt = GNT_M1;
        end else if (req[0]) begin
            gnt = GNT_M0;
        end
    end

    logic unused_last_gnt;
    assign unused_last_gnt = ^last_gnt;
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master, one-outstanding AXI-lite read arbiter (optional ARB_ROUND_ROBIN_EN)
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [DATA_LEN-1:0] m0_araddr,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [DATA_LEN-1:0] m0_rdata,
    output logic [2:0]          m0_rresp,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [DATA_LEN-1:0] m1_araddr,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [DATA_LEN-1:0] m1_rdata,
    output logic [2:0]          m1_rresp,
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [DATA_LEN-1:0] s_araddr,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [DATA_LEN-1:0] s_rdata,
    input  logic [2:0]          s_rresp
);

    arb_state_e          state_q, state_d;
    arb_gnt_e            gnt_q, gnt_d;
    arb_gnt_e            pick_gnt, last_gnt;
    logic                s_arvalid_q, s_arvalid_d;
    logic [DATA_LEN-1:0] s_araddr_q, s_araddr_d;
    logic                g0, g1, r_pass, r_hs;

    axi_rd_arb_pick u_pick (
        .req      ({m1_arvalid, m0_arvalid}),
        .last_gnt (last_gnt),
        .gnt      (pick_gnt)
    );

`ifdef ARB_ROUND_ROBIN_EN
    arb_gnt_e last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (state_q == ARB_IDLE && pick_gnt != GNT_NONE) begin
            last_d = pick_gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= GNT_M1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_gnt = last_q;
`else
    assign last_gnt = GNT_M1;
`endif

    assign g0 = (gnt_q == GNT_M0);
    assign g1 = (gnt_q == GNT_M1);

    // The R channel is open in R, and in AR on the cycle the address is accepted (fast path).
    assign r_pass = (state_q == ARB_R) || (state_q == ARB_AR && s_arready);

    assign m0_arready = (state_q == ARB_AR) && g0 && s_arready;
    assign m1_arready = (state_q == ARB_AR) && g1 && s_arready;
    assign m0_rvalid  = r_pass && g0 && s_rvalid;
    assign m1_rvalid  = r_pass && g1 && s_rvalid;
    assign s_rready   = r_pass && ((g0 && m0_rready) || (g1 && m1_rready));
    assign r_hs       = s_rvalid && s_rready;

    assign s_arvalid  = s_arvalid_q && (state_q == ARB_AR);
    assign s_araddr   = s_araddr_q;

    assign m0_rdata   = r_pass ? s_rdata : '0;
    assign m1_rdata   = r_pass ? s_rdata : '0;
    assign m0_rresp   = r_pass ? s_rresp : RESP_OKAY;
    assign m1_rresp   = r_pass ? s_rresp : RESP_OKAY;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        s_arvalid_d = s_arvalid_q;
        s_araddr_d  = s_araddr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_gnt != GNT_NONE) begin
                    gnt_d       = pick_gnt;
                    s_araddr_d  = (pick_gnt == GNT_M1) ? m1_araddr : m0_araddr;
                    s_arvalid_d = 1'b1;
                    state_d     = ARB_AR;
                end
            end
            ARB_AR: begin
                if (s_arready) begin
                    s_arvalid_d = 1'b0;
                    if (r_hs) begin
                        state_d = ARB_IDLE;
                        gnt_d   = GNT_NONE;
                    end else begin
                        state_d = ARB_R;
                    end
                end
            end
            ARB_R: begin
                if (r_hs) begin
                    state_d = ARB_IDLE;
                    gnt_d   = GNT_NONE;
                end
            end
            default: begin
                state_d     = ARB_IDLE;
                gnt_d       = GNT_NONE;
                s_arvalid_d = 1'b0;
                s_araddr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= GNT_NONE;
            s_arvalid_q <= 1'b0;
            s_araddr_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            s_arvalid_q <= s_arvalid_d;
            s_araddr_q  <= s_araddr_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - scoreboard bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_arvalid = 1'b0, m0_arready, m0_rvalid, m0_rready = 1'b1;
    logic [31:0] m0_araddr = '0, m0_rdata;
    logic [2:0]  m0_rresp;
    logic        m1_arvalid = 1'b0, m1_arready, m1_rvalid, m1_rready = 1'b1;
    logic [31:0] m1_araddr = '0, m1_rdata;
    logic [2:0]  m1_rresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_araddr, s_rdata;
    logic [2:0]  s_rresp;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.DATA_LEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
    );

    typedef struct { int m; logic [31:0] addr; } ar_exp_t;
    typedef struct { int m; logic [31:0] data; logic [2:0] resp; } r_exp_t;
    typedef struct { int ar_wait; int r_wait; bit fast; logic [31:0] data; logic [2:0] resp; } slv_t;

    ar_exp_t exp_ar[$];
    r_exp_t  exp_r[$];
    slv_t    slv_q[$];
    int      checks = 0;
    int      failures = 0;
    int      tb_last = 1;
    bit      slv_abort = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input int m, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] resp, input int ar_wait, input int r_wait, input bit fast);
        ar_exp_t a;
        r_exp_t  r;
        slv_t    s;
        a.m = m; a.addr = addr;
        r.m = m; r.data = data; r.resp = resp;
        s.ar_wait = ar_wait; s.r_wait = r_wait; s.fast = fast; s.data = data; s.resp = resp;
        exp_ar.push_back(a);
        exp_r.push_back(r);
        slv_q.push_back(s);
        tb_last = m;
    endtask

    function automatic int first_of_pair();
`ifdef ARB_ROUND_ROBIN_EN
        return (tb_last == 1) ? 0 : 1;
`else
        return 1;
`endif
    endfunction

    task automatic issue_pair(input logic [31:0] a0, input logic [31:0] d0,
                              input logic [31:0] a1, input logic [31:0] d1);
        if (first_of_pair() == 1) begin
            issue(1, a1, d1, 3'b000, 0, 0, 1'b0);
            issue(0, a0, d0, 3'b000, 0, 0, 1'b0);
        end else begin
            issue(0, a0, d0, 3'b000, 0, 0, 1'b0);
            issue(1, a1, d1, 3'b000, 0, 0, 1'b0);
        end
        m0_araddr = a0; m1_araddr = a1;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_ar.size() != 0 || exp_r.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, exp_ar.size() + exp_r.size(), 0);
        @(posedge clk); #1;
    endtask

    // Masters drop arvalid once their address has been accepted.
    initial begin
        bit h0, h1;
        forever begin
            @(negedge clk);
            h0 = m0_arvalid && m0_arready;
            h1 = m1_arvalid && m1_arready;
            @(posedge clk); #1;
            if (h0) m0_arvalid = 1'b0;
            if (h1) m1_arvalid = 1'b0;
        end
    end

    // Slave model driven by the per-transaction timing table in slv_q.
    initial begin
        slv_t cfg;
        bit   done, ar_hs, r_hs;
        int   n;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
        forever begin
            @(posedge clk); #1;
            if (s_arvalid && slv_q.size() != 0 && !slv_abort) begin
                cfg = slv_q.pop_front();
                done = 1'b0;
                n = 0;
                repeat (cfg.ar_wait) begin @(posedge clk); #1; end
                s_arready = 1'b1;
                if (cfg.fast) begin
                    s_rvalid = 1'b1; s_rdata = cfg.data; s_rresp = cfg.resp;
                end
                while (!done) begin
                    @(negedge clk);
                    ar_hs = s_arvalid && s_arready;
                    r_hs  = s_rvalid && s_rready;
                    @(posedge clk); #1;
                    n++;
                    if (slv_abort || n > 200) begin
                        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
                        done = 1'b1;
                    end else begin
                        if (ar_hs) begin
                            s_arready = 1'b0;
                            if (!cfg.fast) begin
                                repeat (cfg.r_wait) begin @(posedge clk); #1; end
                                s_rvalid = 1'b1; s_rdata = cfg.data; s_rresp = cfg.resp;
                            end
                        end
                        if (r_hs) begin
                            s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
                            done = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents an AR or R handshake.
    ar_exp_t mon_a;
    r_exp_t  mon_r;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (s_arvalid && s_arready) begin
                    if (exp_ar.size() == 0) begin
                        check("unexpected_ar", 1, 0);
                    end else begin
                        mon_a = exp_ar.pop_front();
                        check("s_araddr", s_araddr, mon_a.addr);
                        check("arready_granted", mon_a.m ? m1_arready : m0_arready, 1);
                        check("arready_other", mon_a.m ? m0_arready : m1_arready, 0);
                    end
                end
                if (m0_rvalid || m1_rvalid) begin
                    if (exp_r.size() == 0) begin
                        check("unexpected_rvalid", 1, 0);
                    end else begin
                        mon_r = exp_r[0];
                        check("rvalid_other", mon_r.m ? m0_rvalid : m1_rvalid, 0);
                        if (mon_r.m ? (m1_rvalid && m1_rready) : (m0_rvalid && m0_rready)) begin
                            void'(exp_r.pop_front());
                            check("rdata", mon_r.m ? m1_rdata : m0_rdata, mon_r.data);
                            check("rresp", mon_r.m ? m1_rresp : m0_rresp, mon_r.resp);
                            check("s_rready_hs", s_rready, 1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_arvalid", s_arvalid, 0);
        check("rst_s_araddr", s_araddr, 0);
        check("rst_s_rready", s_rready, 0);
        check("rst_arready", {m1_arready, m0_arready}, 0);
        check("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single m0 read
        issue(0, 32'h8000_0000, 32'h0000_0013, 3'b000, 0, 0, 1'b0);
        m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
        wait_done("m0_single_done");

        // Simultaneous pair
        issue_pair(32'h8000_0004, 32'hA0A0_0004, 32'h8000_1000, 32'hB1B1_1000);
        wait_done("pair1_done");

        // Fast path: arready and rvalid in the same cycle
        issue(0, 32'h8000_0008, 32'h1111_2222, 3'b000, 1, 0, 1'b1);
        m0_araddr = 32'h8000_0008; m0_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!m0_arready && n < 50);
        check("fast_arready_seen", m0_arready, 1);
        check("fast_rvalid_with_arready", m0_rvalid, 1);
        wait_done("fast_done");

        // Error response to m1
        issue(1, 32'h8000_4000, 32'hDEAD_BEEF, 3'b010, 0, 1, 1'b0);
        m1_araddr = 32'h8000_4000; m1_arvalid = 1'b1;
        wait_done("err_done");

        // Second simultaneous pair
        issue_pair(32'h8000_0010, 32'h0000_0010, 32'h8000_1010, 32'h0000_1010);
        wait_done("pair2_done");

        // Normal m0 read after the error
        issue(0, 32'h8000_000C, 32'h0000_0042, 3'b000, 2, 2, 1'b0);
        m0_araddr = 32'h8000_000C; m0_arvalid = 1'b1;
        wait_done("m0_after_err_done");

        // m1 stalls the R channel for 5 cycles
        m1_rready = 1'b0;
        issue(1, 32'h8000_2000, 32'hCAFE_F00D, 3'b000, 0, 0, 1'b0);
        m1_araddr = 32'h8000_2000; m1_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_rvalid && n < 50);
        check("stall_rvalid_seen", s_rvalid, 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_s_rready", s_rready, 0);
            check("stall_m1_rvalid", m1_rvalid, 1);
            check("stall_m1_rdata", m1_rdata, 32'hCAFE_F00D);
            @(negedge clk);
        end
        @(posedge clk); #1;
        m1_rready = 1'b1;
        wait_done("stall_done");

        // Asynchronous reset while in R
        m1_rready = 1'b0;
        issue(1, 32'h8000_3000, 32'h5555_AAAA, 3'b000, 0, 0, 1'b0);
        m1_araddr = 32'h8000_3000; m1_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!m1_rvalid && n < 50);
        check("rst_mid_rvalid_seen", m1_rvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_s_arvalid", s_arvalid, 0);
        check("arst_s_araddr", s_araddr, 0);
        check("arst_s_rready", s_rready, 0);
        check("arst_arready", {m1_arready, m0_arready}, 0);
        check("arst_rvalid", {m1_rvalid, m0_rvalid}, 0);
        check("arst_m1_rdata", m1_rdata, 0);
        slv_abort = 1'b1;
        exp_ar.delete();
        exp_r.delete();
        m1_rready = 1'b1;
        m0_araddr = 32'h8000_0100; m0_arvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        slv_abort = 1'b0;
        tb_last = 1;
        issue(0, 32'h8000_0100, 32'h0000_0777, 3'b000, 0, 0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle_arvalid", s_arvalid, 0);
        @(negedge clk);
        check("post_rst_arvalid", s_arvalid, 1);
        check("post_rst_araddr", s_araddr, 32'h8000_0100);
        wait_done("post_rst_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
